// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative MULT/MULTU/DIV/DIVU (one bit per cycle) plus MTHI/MTLO into hi/lo; start/op/A/B in, flush cancels, busy/done/hi/lo out
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic is_div, neg_q, neg_r, dz, sa, sb, ge;
  logic [WIDTH-1:0] hw, lw, bm, am, bmag;
  logic [WIDTH:0] sum, sh, dif;
  logic [2*WIDTH-1:0] prod;
  assign sa = ~op[0] & A[WIDTH-1];
  assign sb = ~op[0] & B[WIDTH-1];
  assign am = sa ? -A : A;
  assign bmag = sb ? -B : B;
  assign sum = {1'b0, hw} + (lw[0] ? {1'b0, bm} : '0);
  assign sh = {hw, lw[WIDTH-1]};
  assign ge = sh >= {1'b0, bm};
  assign dif = sh - {1'b0, bm};
  assign prod = neg_q ? -{hw, lw} : {hw, lw};
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hw <= '0;
      lw <= '0;
      bm <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && op[2:1] == 2'b10) begin
          if (op[0]) lo <= A;
          else hi <= A;
          done <= 1'b1;
        end else if (start && !op[2] && !flush) begin
          state <= RUN;
          cnt <= '0;
          is_div <= op[1];
          neg_q <= sa ^ sb;
          neg_r <= sa;
          dz <= B == '0;
          hw <= '0;
          lw <= am;
          bm <= bmag;
        end
      end else if (flush) begin
        state <= IDLE;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        hw <= is_div ? (ge ? dif[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
        lw <= is_div ? {lw[WIDTH-2:0], ge} : {sum[0], lw[WIDTH-1:1]};
      end else begin
        state <= IDLE;
        done <= 1'b1;
        hi <= is_div ? (neg_r ? -hw : hw) : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? (dz ? '1 : neg_q ? -lw : lw) : prod[WIDTH-1:0];
      end
    end
  end
endmodule
